// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings:
// PLL lock/relock inputs plus the reset, ready and debug outputs.
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             locked;
  logic             relock_req;
  logic             pll_rst;
  logic             sys_reset;
  logic             ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] loss_count;

  modport master (
    output locked,
    output relock_req,
    input  pll_rst,
    input  sys_reset,
    input  ready,
    input  state,
    input  loss_count
  );

  modport slave (
    input  locked,
    input  relock_req,
    output pll_rst,
    output sys_reset,
    output ready,
    output state,
    output loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses the PLL reset,
// filters the synchronised locked flag, then releases the core reset after a holdoff.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 1024,
  parameter int HOLDOFF        = 256,
  parameter int LOCK_TIMEOUT   = 5000000,
  parameter int CNT_W          = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.slave  bus
);

  localparam int RST_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int FLT_W = (LOCK_FILTER > 1)    ? $clog2(LOCK_FILTER)    : 1;
  localparam int HLD_W = (HOLDOFF > 1)        ? $clog2(HOLDOFF)        : 1;
  localparam int TMO_W = (LOCK_TIMEOUT > 1)   ? $clog2(LOCK_TIMEOUT)   : 1;

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_HOLDOFF   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;
  logic [RST_W-1:0]       rst_cnt_reg, rst_cnt_next;
  logic [FLT_W-1:0]       flt_cnt_reg, flt_cnt_next;
  logic [HLD_W-1:0]       hld_cnt_reg, hld_cnt_next;
  logic [TMO_W-1:0]       tmo_cnt_reg, tmo_cnt_next;
  logic [CNT_W-1:0]       loss_count_reg, loss_count_next;
  logic                   pll_rst_reg, pll_rst_next;
  logic                   sys_reset_reg, sys_reset_next;
  logic                   ready_reg, ready_next;
  logic                   tmo_expired;

  // Raw locked is asynchronous; only the last synchroniser stage is used downstream.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      sync_reg[0] <= bus.locked;
    end
  end

  assign locked_s    = sync_reg[SYNC_STAGES-1];
  assign tmo_expired = (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_PLL_RST;
      rst_cnt_reg    <= '0;
      flt_cnt_reg    <= '0;
      hld_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      loss_count_reg <= '0;
      pll_rst_reg    <= 1'b1;
      sys_reset_reg  <= 1'b1;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rst_cnt_reg    <= rst_cnt_next;
      flt_cnt_reg    <= flt_cnt_next;
      hld_cnt_reg    <= hld_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      loss_count_reg <= loss_count_next;
      pll_rst_reg    <= pll_rst_next;
      sys_reset_reg  <= sys_reset_next;
      ready_reg      <= ready_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rst_cnt_next    = rst_cnt_reg;
    flt_cnt_next    = flt_cnt_reg;
    hld_cnt_next    = hld_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    loss_count_next = loss_count_reg;

    if (bus.relock_req) begin
      state_next   = S_PLL_RST;
      rst_cnt_next = '0;
      tmo_cnt_next = '0;
    end else begin
      case (state_reg)
        S_PLL_RST: begin
          tmo_cnt_next = '0;
          if (rst_cnt_reg == RST_LAST) begin
            state_next   = S_WAIT_LOCK;
            rst_cnt_next = '0;
          end else begin
            rst_cnt_next = rst_cnt_reg + RST_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (tmo_expired) begin
            state_next   = S_PLL_RST;
            rst_cnt_next = '0;
            tmo_cnt_next = '0;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            if (locked_s) begin
              state_next   = S_FILTER;
              flt_cnt_next = '0;
            end
          end
        end

        // Timeout is checked first so a glitchy lock cannot outrun the deadline.
        S_FILTER: begin
          if (tmo_expired) begin
            state_next   = S_PLL_RST;
            rst_cnt_next = '0;
            tmo_cnt_next = '0;
          end else if (!locked_s) begin
            state_next   = S_WAIT_LOCK;
            flt_cnt_next = '0;
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
          end else if (flt_cnt_reg == FLT_LAST) begin
            state_next   = S_HOLDOFF;
            flt_cnt_next = '0;
            hld_cnt_next = '0;
            tmo_cnt_next = '0;
          end else begin
            flt_cnt_next = flt_cnt_reg + FLT_W'(1);
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
          end
        end

        S_HOLDOFF: begin
          tmo_cnt_next = '0;
          if (!locked_s) begin
            state_next   = S_WAIT_LOCK;
            hld_cnt_next = '0;
          end else if (hld_cnt_reg == HLD_LAST) begin
            state_next   = S_RUN;
            hld_cnt_next = '0;
          end else begin
            hld_cnt_next = hld_cnt_reg + HLD_W'(1);
          end
        end

        S_RUN: begin
          tmo_cnt_next = '0;
          if (!locked_s) begin
            state_next = S_WAIT_LOCK;
            if (loss_count_reg != {CNT_W{1'b1}}) begin
              loss_count_next = loss_count_reg + CNT_W'(1);
            end
          end
        end

        default: begin
          state_next   = S_PLL_RST;
          rst_cnt_next = '0;
          flt_cnt_next = '0;
          hld_cnt_next = '0;
          tmo_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_comb begin
    pll_rst_next   = (state_next == S_PLL_RST);
    sys_reset_next = (state_next != S_RUN);
    ready_next     = (state_next == S_RUN);
  end

  assign bus.pll_rst    = pll_rst_reg;
  assign bus.sys_reset  = sys_reset_reg;
  assign bus.ready      = ready_reg;
  assign bus.state      = state_reg;
  assign bus.loss_count = loss_count_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: a vector table for the lock-up timeline,
// then hand-written sequences for lock loss, saturation, timeout, relock and reset.
module tb_pll_lock_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_FILTER    = 8;
  localparam int HOLDOFF        = 4;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int CNT_W          = 2;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_lock_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_sequencer #(
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_FILTER   (LOCK_FILTER),
    .HOLDOFF       (HOLDOFF),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  int checks  = 0;
  int errors  = 0;
  int edge_no = -1;

  typedef struct {
    int upto;
    bit lk;
    int st;
    bit prst;
    bit sys;
    bit rdy;
    int loss;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int st, input int prst,
                            input int sys, input int rdy, input int loss);
    check({name, ".state"},      int'(bus.state),      st);
    check({name, ".pll_rst"},    int'(bus.pll_rst),    prst);
    check({name, ".sys_reset"},  int'(bus.sys_reset),  sys);
    check({name, ".ready"},      int'(bus.ready),      rdy);
    check({name, ".loss_count"}, int'(bus.loss_count), loss);
    $display("%s edge %0d: state=%0d pll_rst=%0d sys_reset=%0d ready=%0d loss_count=%0d",
             name, edge_no, bus.state, bus.pll_rst, bus.sys_reset, bus.ready, bus.loss_count);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    edge_no++;
  endtask

  // Releases reset just after an edge, so the next rising edge is edge 0.
  task automatic do_reset();
    rst            = 1'b1;
    bus.locked     = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    check_outs("reset", 0, 1, 1, 0, 0);
    rst     = 1'b0;
    edge_no = -1;
  endtask

  task automatic wait_state(input string name, input int st, input int budget);
    int n;
    n = 0;
    while (int'(bus.state) != st && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(bus.state), st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_hi;
    bit seen_filter;
    bit seen_late;
    int exp_loss;

    //            upto lk  st prst sys rdy loss
    vecs[0] = '{   2, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0};
    vecs[1] = '{   4, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{   9, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{  11, 1'b1, 1, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{  12, 1'b1, 2, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{  19, 1'b1, 2, 1'b0, 1'b1, 1'b0, 0};
    vecs[6] = '{  20, 1'b1, 3, 1'b0, 1'b1, 1'b0, 0};
    vecs[7] = '{  24, 1'b1, 4, 1'b0, 1'b0, 1'b1, 0};

    bus.locked     = 1'b0;
    bus.relock_req = 1'b0;

    // Lock-up timeline with locked first sampled high at edge 10.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.locked = vecs[i].lk;
      while (edge_no < vecs[i].upto) tick();
      check_outs($sformatf("vec%0d", i), vecs[i].st, int'(vecs[i].prst),
                 int'(vecs[i].sys), int'(vecs[i].rdy), vecs[i].loss);
    end
    while (edge_no < 23) tick();

    // Three-cycle lock drop in RUN: first low sample at edge 31.
    while (edge_no < 30) tick();
    bus.locked = 1'b0;
    while (edge_no < 32) tick();
    check_outs("drop_before", 4, 0, 0, 1, 0);
    tick();
    check_outs("drop_resp", 1, 0, 1, 0, 1);
    bus.locked = 1'b1;
    while (edge_no < 44) tick();
    check("recover_holdoff", int'(bus.state), 3);
    while (edge_no < 47) tick();
    check("recover_not_yet", int'(bus.state), 3);
    tick();
    check_outs("recover_run", 4, 0, 0, 1, 1);

    // Further losses: loss_count goes 2, 3, then stays at 3.
    for (int k = 2; k <= 4; k++) begin
      exp_loss = (k > 3) ? 3 : k;
      tick();
      bus.locked = 1'b0;
      repeat (3) tick();
      check_outs($sformatf("loss%0d", k), 1, 0, 1, 0, exp_loss);
      bus.locked = 1'b1;
      wait_state($sformatf("loss%0d_rerun", k), 4, 40);
    end

    // relock_req in RUN: straight to PLL_RST, loss_count untouched.
    tick();
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    check_outs("relock", 0, 1, 1, 0, 3);

    // Asynchronous reset in the middle of HOLDOFF.
    wait_state("relock_holdoff", 3, 40);
    tick();
    check("holdoff_mid", int'(bus.state), 3);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 0, 1, 1, 0, 0);

    // locked held low: PLL reset re-pulses for 4 of every 68 cycles.
    do_reset();
    for (int e = 0; e <= 210; e++) begin
      tick();
      if (e >= 4) begin
        exp_hi = (e >= 67) && (((e - 67) % 68) < 4);
        check("nolock.pll_rst", int'(bus.pll_rst), int'(exp_hi));
        check("nolock.state", int'(bus.state), exp_hi ? 0 : 1);
        check("nolock.sys_reset", int'(bus.sys_reset), 1);
        check("nolock.loss_count", int'(bus.loss_count), 0);
        if (exp_hi && ((e - 67) % 68) == 0)
          $display("nolock edge %0d: pll_rst re-pulse state=%0d", e, bus.state);
      end
    end

    // locked toggling 5 high / 1 low: filter never completes, timeout fires.
    do_reset();
    seen_filter = 1'b0;
    seen_late   = 1'b0;
    for (int e = 0; e <= 67; e++) begin
      bus.locked = ((e % 6) != 5);
      tick();
      if (int'(bus.state) == 2) seen_filter = 1'b1;
      if (int'(bus.state) >= 3) seen_late = 1'b1;
      if (e >= 4 && e <= 66) begin
        if (int'(bus.state) == 0)
          check("glitch.early_pll_rst", int'(bus.state), 1);
      end
      if (e == 66) check("glitch.pre_timeout_pll_rst", int'(bus.pll_rst), 0);
    end
    check_outs("glitch_timeout", 0, 1, 1, 0, 0);
    check("glitch.saw_filter", int'(seen_filter), 1);
    check("glitch.no_holdoff", int'(seen_late), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
